regfile_write_arbiter: RTL and testbench

- Owns the single write port of the 32 x 64-bit register file.
- After reset, sequences a zero-scrub of every register.
- Then shares the write port between two writeback requesters: A (ALU writeback) and B (load writeback).
- Arbitration is round-robin. Writes to the hardwired zero register are suppressed.

---
 rtl/regfile_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32 x 64 register file: zero-scrubs every register after reset,
// then round-robins writebacks from requester A (ALU) and B (load), dropping writes to XZR.
module regfile_write_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              regWrite,
  output logic              init_done
);

  localparam int CNT_W      = ADDR_W + 1;
  localparam int LAST_SCRUB = (ZERO_REG == NUM_REGS - 1) ? NUM_REGS - 2 : NUM_REGS - 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s, cnt_inc_s;
  logic              prio_r, prio_s;          // 1'b0: A has priority, 1'b1: B
  logic              reg_write_r, reg_write_s;
  logic [ADDR_W-1:0] write_reg_r, write_reg_s;
  logic [DATA_W-1:0] write_data_r, write_data_s;
  logic              init_done_r, init_done_s;
  logic              grant_a_s, grant_b_s;
  logic [ADDR_W-1:0] gnt_reg_s;
  logic [DATA_W-1:0] gnt_data_s;

  // Round-robin grant; nothing is accepted while the scrub is running.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (state_r == ST_RUN) begin
      grant_a_s = a_valid & (~b_valid | ~prio_r);
      grant_b_s = b_valid & (~a_valid | prio_r);
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  assign a_ready = grant_a_s;
  assign b_ready = grant_b_s;

  // Scrub counter step, hopping over the hardwired-zero register.
  always_comb begin
    cnt_inc_s = cnt_r + CNT_W'(1);
    if ((cnt_r + CNT_W'(1)) == CNT_W'(ZERO_REG)) begin
      cnt_inc_s = cnt_r + CNT_W'(2);
    end else begin
      cnt_inc_s = cnt_r + CNT_W'(1);
    end
  end

  // Next-state and next-output logic for the scrub/run sequencer.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    prio_s       = prio_r;
    reg_write_s  = 1'b0;
    write_reg_s  = write_reg_r;
    write_data_s = write_data_r;
    init_done_s  = init_done_r;
    gnt_reg_s    = grant_b_s ? b_reg  : a_reg;
    gnt_data_s   = grant_b_s ? b_data : a_data;
    case (state_r)
      ST_INIT: begin
        if (cnt_r > CNT_W'(LAST_SCRUB)) begin
          state_s     = ST_RUN;
          init_done_s = 1'b1;
        end else begin
          if (cnt_r != CNT_W'(ZERO_REG)) begin
            reg_write_s  = 1'b1;
            write_reg_s  = cnt_r[ADDR_W-1:0];
            write_data_s = {DATA_W{1'b0}};
          end else begin
            reg_write_s = 1'b0;
          end
          cnt_s = cnt_inc_s;
        end
      end
      ST_RUN: begin
        if (grant_a_s | grant_b_s) begin
          prio_s = grant_a_s;
          // XZR grants complete the handshake but never reach the register file
          if (gnt_reg_s != ADDR_W'(ZERO_REG)) begin
            reg_write_s  = 1'b1;
            write_reg_s  = gnt_reg_s;
            write_data_s = gnt_data_s;
          end else begin
            reg_write_s = 1'b0;
          end
        end else begin
          reg_write_s = 1'b0;
        end
      end
      default: begin
        state_s     = ST_INIT;
        cnt_s       = {CNT_W{1'b0}};
        init_done_s = 1'b0;
      end
    endcase
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_INIT;
      cnt_r        <= {CNT_W{1'b0}};
      prio_r       <= 1'b0;
      reg_write_r  <= 1'b0;
      write_reg_r  <= {ADDR_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
      init_done_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      prio_r       <= prio_s;
      reg_write_r  <= reg_write_s;
      write_reg_r  <= write_reg_s;
      write_data_r <= write_data_s;
      init_done_r  <= init_done_s;
    end
  end

  assign regWrite  = reg_write_r;
  assign writeReg  = write_reg_r;
  assign writeData = write_data_r;
  assign init_done = init_done_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic against a
// transaction-level model (scrub list, last-granted priority, mirrored register file).
module tb_regfile_write_arbiter;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;

  logic              clk;
  logic              reset;
  logic              a_valid, b_valid;
  logic [ADDR_W-1:0] a_reg, b_reg;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              regWrite;
  logic              init_done;

  int n_vec;
  int n_miss;

  // reference model state
  int                scrub_q[$];
  int                e;
  bit                prio_b;
  bit                exp_rw;
  logic [ADDR_W-1:0] exp_wr;
  logic [DATA_W-1:0] exp_wd;
  bit                hold_ok;
  bit                m_ga, m_gb;
  bit                pend_a, pend_b;
  logic [DATA_W-1:0] mrf [NUM_REGS];
  logic [DATA_W-1:0] drf [NUM_REGS];

  regfile_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite), .init_done(init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    e       = 0;
    prio_b  = 1'b0;
    exp_rw  = 1'b0;
    exp_wr  = '0;
    exp_wd  = '0;
    hold_ok = 1'b1;
  endtask

  // One clock: called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    bit                run;
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
    #1;
    run = (e > scrub_q.size());
    if (run && a_valid && b_valid) begin
      m_ga = !prio_b;
      m_gb = prio_b;
    end else begin
      m_ga = run && a_valid;
      m_gb = run && b_valid;
    end
    check_val("a_ready", a_ready, m_ga);
    check_val("b_ready", b_ready, m_gb);
    @(posedge clk);
    if (!run) begin
      e++;
      if (e <= scrub_q.size()) begin
        exp_rw      = 1'b1;
        exp_wr      = ADDR_W'(scrub_q[e-1]);
        exp_wd      = '0;
        mrf[exp_wr] = '0;
        hold_ok     = 1'b1;
      end else begin
        exp_rw = 1'b0;
      end
    end else if (m_ga || m_gb) begin
      prio_b = m_ga;
      r = m_ga ? a_reg : b_reg;
      d = m_ga ? a_data : b_data;
      if (r != ADDR_W'(ZERO_REG)) begin
        exp_rw  = 1'b1;
        exp_wr  = r;
        exp_wd  = d;
        mrf[r]  = d;
        hold_ok = 1'b1;
      end else begin
        exp_rw  = 1'b0;
        hold_ok = 1'b0;
      end
    end else begin
      exp_rw = 1'b0;
    end
    #1;
    check_val("regWrite", regWrite, exp_rw);
    check_val("init_done", init_done, e > scrub_q.size());
    if (exp_rw || hold_ok) begin
      check_val("writeReg", writeReg, exp_wr);
      check_val("writeData", writeData, exp_wd);
    end
    if (regWrite) drf[writeReg] = writeData;
    @(negedge clk);
  endtask

  // Holds whatever requests are valid until each has been granted (bounded).
  task automatic send_pending();
    bit da, db;
    int k;
    da = !a_valid;
    db = !b_valid;
    k  = 0;
    while (!(da && db) && k < 20) begin
      cycle();
      if (m_ga) begin da = 1'b1; a_valid = 1'b0; end
      if (m_gb) begin db = 1'b1; b_valid = 1'b0; end
      k++;
    end
    check_val("send_done", {62'b0, da, db}, 64'h3);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i != ZERO_REG) scrub_q.push_back(i);
      mrf[i] = 64'h5A5A_0000_0000_0000 + 64'(i);
      drf[i] = 64'h5A5A_0000_0000_0000 + 64'(i);
    end
    model_reset();
    reset   = 1'b1;
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;

    @(posedge clk);
    #1;
    check_val("rst_regWrite", regWrite, 1'b0);
    check_val("rst_init_done", init_done, 1'b0);
    check_val("rst_writeReg", writeReg, 5'd0);
    check_val("rst_writeData", writeData, 64'd0);
    check_val("rst_a_ready", a_ready, 1'b0);
    check_val("rst_b_ready", b_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // scrub with both requesters already waiting
    a_valid = 1'b1; a_reg = 5'd1; a_data = 64'hA;
    b_valid = 1'b1; b_reg = 5'd2; b_data = 64'hB;
    repeat (32) cycle();

    // round-robin on sustained contention
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("rr_grant", {62'b0, a_ready, b_ready}, (i % 2 == 0) ? 64'h2 : 64'h1);
      cycle();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    cycle();

    // lone requester, back-to-back
    a_valid = 1'b1; a_reg = 5'd5; a_data = 64'hDEADBEEF;
    cycle();
    a_reg = 5'd6; a_data = 64'h1;
    cycle();
    a_valid = 1'b0;
    cycle();

    // write to XZR still flips priority
    b_valid = 1'b1; b_reg = 5'd31; b_data = 64'hFFFF;
    cycle();
    a_valid = 1'b1; a_reg = 5'd3; a_data = 64'h33;
    b_valid = 1'b1; b_reg = 5'd4; b_data = 64'h44;
    #1;
    check_val("zr_prio_a", {62'b0, a_ready, b_ready}, 64'h2);
    send_pending();

    // same destination, A holds priority
    a_valid = 1'b1; a_reg = 5'd7; a_data = 64'h11;
    b_valid = 1'b1; b_reg = 5'd7; b_data = 64'h22;
    #1;
    check_val("same_prio_a", {62'b0, a_ready, b_ready}, 64'h2);
    send_pending();
    cycle();
    check_val("rf7", drf[7], 64'h22);

    // asynchronous reset while a write is on the port
    a_valid = 1'b1; a_reg = 5'd9;  a_data = 64'h99;
    b_valid = 1'b1; b_reg = 5'd10; b_data = 64'h1010;
    cycle();
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_regWrite", regWrite, 1'b0);
    check_val("mid_rst_init_done", init_done, 1'b0);
    check_val("mid_rst_a_ready", a_ready, 1'b0);
    check_val("mid_rst_b_ready", b_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (32) cycle();

    // random traffic
    pend_a = a_valid;
    pend_b = b_valid;
    repeat (600) begin
      if (!pend_a && $urandom_range(0, 9) < 6) begin
        pend_a = 1'b1;
        a_reg  = ADDR_W'($urandom_range(0, NUM_REGS - 1));
        a_data = {$urandom, $urandom};
      end
      if (!pend_b && $urandom_range(0, 9) < 6) begin
        pend_b = 1'b1;
        b_reg  = ADDR_W'($urandom_range(0, NUM_REGS - 1));
        b_data = {$urandom, $urandom};
      end
      a_valid = pend_a;
      b_valid = pend_b;
      cycle();
      if (m_ga) pend_a = 1'b0;
      if (m_gb) pend_b = 1'b0;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    cycle();

    for (int i = 0; i < NUM_REGS; i++) begin
      check_val("rf_final", drf[i], mrf[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
